// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : cpu_pkg
//  Purpose  : Shared definitions for the four-bit computer: widths, opcodes,
//             ALU function codes, control FSM states and the control word.
//  Revision : 1.0  initial release
// ============================================================================
package cpu_pkg;

  localparam int PC_W    = 4;
  localparam int INSTR_W = 8;

  // Opcodes live in IR[7:4]; 0xD and 0xE are undefined.
  localparam logic [3:0] OP_NOP = 4'h0;
  localparam logic [3:0] OP_LDI = 4'h1;
  localparam logic [3:0] OP_ADD = 4'h2;
  localparam logic [3:0] OP_SUB = 4'h3;
  localparam logic [3:0] OP_AND = 4'h4;
  localparam logic [3:0] OP_OR  = 4'h5;
  localparam logic [3:0] OP_XOR = 4'h6;
  localparam logic [3:0] OP_LDA = 4'h7;
  localparam logic [3:0] OP_STA = 4'h8;
  localparam logic [3:0] OP_OUT = 4'h9;
  localparam logic [3:0] OP_JMP = 4'hA;
  localparam logic [3:0] OP_JZ  = 4'hB;
  localparam logic [3:0] OP_JC  = 4'hC;
  localparam logic [3:0] OP_HLT = 4'hF;

  typedef logic [2:0] alu_op_t;
  localparam alu_op_t ALU_PASS_B = 3'd0;
  localparam alu_op_t ALU_ADD    = 3'd1;
  localparam alu_op_t ALU_SUB    = 3'd2;
  localparam alu_op_t ALU_AND    = 3'd3;
  localparam alu_op_t ALU_OR     = 3'd4;
  localparam alu_op_t ALU_XOR    = 3'd5;

  typedef logic [1:0] state_t;
  localparam state_t ST_FETCH   = 2'd0;
  localparam state_t ST_DECODE  = 2'd1;
  localparam state_t ST_EXECUTE = 2'd2;
  localparam state_t ST_HALT    = 2'd3;

  typedef struct packed {
    alu_op_t alu_op;
    logic    acc_we;
    logic    mem_we;
    logic    out_we;
    logic    acc_src;
    logic    pc_load;
    logic    halt;
    logic    illegal;
  } ctrl_t;

endpackage
`default_nettype wire

// File: rtl/cpu_control_unit_if.sv
`default_nettype none
// ============================================================================
//  Module   : cpu_control_unit_if
//  Purpose  : Bundle between the control unit (master) and the datapath /
//             program memory (slave).
//  Revision : 1.0  initial release
// ============================================================================
interface cpu_ctrl_if #(
  parameter int PC_W    = cpu_pkg::PC_W,
  parameter int INSTR_W = cpu_pkg::INSTR_W
) ();
  logic                 run;
  logic [INSTR_W-1:0]   instr_data;
  logic                 zero_flag;
  logic                 carry_flag;
  logic [PC_W-1:0]      pc;
  logic [3:0]           operand;
  logic [2:0]           alu_op;
  logic                 acc_we;
  logic                 mem_we;
  logic                 out_we;
  logic                 acc_src;
  logic                 halted;
  logic                 illegal;

  modport master (
    input  run, instr_data, zero_flag, carry_flag,
    output pc, operand, alu_op, acc_we, mem_we, out_we, acc_src, halted, illegal
  );

  modport slave (
    output run, instr_data, zero_flag, carry_flag,
    input  pc, operand, alu_op, acc_we, mem_we, out_we, acc_src, halted, illegal
  );
endinterface
`default_nettype wire

// File: rtl/cpu_decoder.sv
`default_nettype none
// ============================================================================
//  Module   : cpu_decoder
//  Purpose  : Combinational opcode + flags to control word translation.
//  Revision : 1.0  initial release
// ============================================================================
module cpu_decoder
  import cpu_pkg::*;
(
  input  logic [3:0] opcode,
  input  logic       zero_flag,
  input  logic       carry_flag,
  output ctrl_t      ctrl
);

  // Translate opcode into strobes; branch decision uses the live flags.
  always_comb begin
    ctrl        = '0;
    ctrl.alu_op = ALU_PASS_B;
    case (opcode)
      OP_NOP: ;
      OP_LDI: ctrl.acc_we = 1'b1;
      OP_ADD: begin ctrl.acc_we = 1'b1; ctrl.alu_op = ALU_ADD; end
      OP_SUB: begin ctrl.acc_we = 1'b1; ctrl.alu_op = ALU_SUB; end
      OP_AND: begin ctrl.acc_we = 1'b1; ctrl.alu_op = ALU_AND; end
      OP_OR:  begin ctrl.acc_we = 1'b1; ctrl.alu_op = ALU_OR;  end
      OP_XOR: begin ctrl.acc_we = 1'b1; ctrl.alu_op = ALU_XOR; end
      OP_LDA: begin ctrl.acc_we = 1'b1; ctrl.acc_src = 1'b1;   end
      OP_STA: ctrl.mem_we  = 1'b1;
      OP_OUT: ctrl.out_we  = 1'b1;
      OP_JMP: ctrl.pc_load = 1'b1;
      OP_JZ:  ctrl.pc_load = zero_flag;
      OP_JC:  ctrl.pc_load = carry_flag;
      OP_HLT: ctrl.halt    = 1'b1;
      default: ctrl.illegal = 1'b1;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/cpu_control_unit.sv
`default_nettype none
// ============================================================================
//  Module   : cpu_control_unit
//  Purpose  : Fetch/decode/execute sequencer. Owns PC, IR and the control
//             FSM; strobes are registered so none depends on instr_data.
//  Revision : 1.0  initial release
// ============================================================================
module cpu_control_unit
  import cpu_pkg::*;
#(
  parameter int PC_W    = cpu_pkg::PC_W,
  parameter int INSTR_W = cpu_pkg::INSTR_W
) (
  input  logic      clk,
  input  logic      reset,
  cpu_ctrl_if.master bus
);

  state_t             state;
  logic [PC_W-1:0]    pc;
  logic [INSTR_W-1:0] ir;
  ctrl_t              dec;

  alu_op_t            alu_op_q;
  logic               acc_we_q;
  logic               mem_we_q;
  logic               out_we_q;
  logic               acc_src_q;
  logic               illegal_q;
  logic               halt_q;

  // IR stays stable through DECODE and EXECUTE, so the decoder can feed
  // both the registered strobes and the EXECUTE-time branch decision.
  cpu_decoder u_decoder (
    .opcode     (ir[INSTR_W-1 -: 4]),
    .zero_flag  (bus.zero_flag),
    .carry_flag (bus.carry_flag),
    .ctrl       (dec)
  );

  // Control FSM, program counter, instruction register and strobe registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_FETCH;
      pc        <= '0;
      ir        <= '0;
      alu_op_q  <= ALU_PASS_B;
      acc_we_q  <= 1'b0;
      mem_we_q  <= 1'b0;
      out_we_q  <= 1'b0;
      acc_src_q <= 1'b0;
      illegal_q <= 1'b0;
      halt_q    <= 1'b0;
    end else begin
      case (state)
        ST_FETCH: begin
          if (bus.run) begin
            ir    <= bus.instr_data;
            pc    <= pc + 1'b1;
            state <= ST_DECODE;
          end
        end
        ST_DECODE: begin
          alu_op_q  <= dec.alu_op;
          acc_we_q  <= dec.acc_we;
          mem_we_q  <= dec.mem_we;
          out_we_q  <= dec.out_we;
          acc_src_q <= dec.acc_src;
          illegal_q <= dec.illegal;
          halt_q    <= dec.halt;
          state     <= ST_EXECUTE;
        end
        ST_EXECUTE: begin
          // Strobes live for this one cycle only.
          alu_op_q  <= ALU_PASS_B;
          acc_we_q  <= 1'b0;
          mem_we_q  <= 1'b0;
          out_we_q  <= 1'b0;
          acc_src_q <= 1'b0;
          illegal_q <= 1'b0;
          halt_q    <= 1'b0;
          if (dec.pc_load) begin
            pc <= PC_W'(ir[3:0]);
          end
          state <= halt_q ? ST_HALT : ST_FETCH;
        end
        ST_HALT: ;
        default: state <= ST_FETCH;
      endcase
    end
  end

  assign bus.pc      = pc;
  assign bus.operand = ir[3:0];
  assign bus.alu_op  = alu_op_q;
  assign bus.acc_we  = acc_we_q;
  assign bus.mem_we  = mem_we_q;
  assign bus.out_we  = out_we_q;
  assign bus.acc_src = acc_src_q;
  assign bus.illegal = illegal_q;
  assign bus.halted  = (state == ST_HALT);

endmodule
`default_nettype wire

// File: tb/tb_cpu_control_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_cpu_control_unit
//  Purpose  : Self-checking bench; instruction-level reference model with
//             randomized programs, run gating and flags.
//  Revision : 1.0  initial release
// ============================================================================
module tb_cpu_control_unit;

  logic clk = 1'b0;
  logic reset;
  logic [7:0] prog [16];

  int n_checks = 0;
  int n_pass   = 0;

  // Model state
  logic [3:0] m_pc;
  bit         force_run;
  int         flag_mode;   // 0 random, 1 both flags 0, 2 both flags 1

  cpu_ctrl_if bus ();

  assign bus.instr_data = prog[bus.pc];

  cpu_control_unit dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
  endtask

  // {acc_we, mem_we, out_we, acc_src, illegal, alu_op[2:0]}
  function automatic logic [7:0] outs();
    return {bus.acc_we, bus.mem_we, bus.out_we, bus.acc_src, bus.illegal, bus.alu_op};
  endfunction

  // Expected execute-cycle strobes straight from the opcode table.
  function automatic logic [7:0] exp_exec(input logic [3:0] op);
    logic       aw;
    logic [2:0] ao;
    aw = (op >= 4'd1) && (op <= 4'd7);
    ao = (op >= 4'd2 && op <= 4'd6) ? 3'(op - 4'd1) : 3'd0;
    return {aw, op == 4'd8, op == 4'd9, op == 4'd7, (op == 4'hD) || (op == 4'hE), ao};
  endfunction

  task automatic drive_flags();
    case (flag_mode)
      1:       begin bus.zero_flag = 1'b0; bus.carry_flag = 1'b0; end
      2:       begin bus.zero_flag = 1'b1; bus.carry_flag = 1'b1; end
      default: begin bus.zero_flag = 1'($urandom); bus.carry_flag = 1'($urandom); end
    endcase
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset   = 1'b1;
    bus.run = 1'($urandom);
    tick();
    tick();
    check("rst_pc", 32'(bus.pc), 32'd0);
    check("rst_outs", 32'(outs()), 32'd0);
    check("rst_halted", 32'(bus.halted), 32'd0);
    check("rst_operand", 32'(bus.operand), 32'd0);
    reset = 1'b0;
    m_pc  = 4'd0;
  endtask

  // Runs one instruction through the DUT against the model. Returns 1 when
  // the instruction was HLT. With abort set, reset is asserted during EXECUTE.
  task automatic do_instr(input bit abort, output bit halted_now);
    int         waits;
    logic [7:0] ins;
    logic [3:0] op;
    logic [3:0] opd;
    bit         take;
    bit         ran;
    halted_now = 1'b0;
    waits      = 0;
    // FETCH: wait for run
    ran = 1'b0;
    while (!ran) begin
      check("fetch_pc", 32'(bus.pc), 32'(m_pc));
      check("fetch_outs", 32'(outs()), 32'd0);
      check("fetch_halted", 32'(bus.halted), 32'd0);
      bus.run = (force_run || waits > 6) ? 1'b1 : ($urandom_range(0, 3) != 0);
      drive_flags();
      ran = bus.run;
      tick();
      waits++;
    end
    ins  = prog[m_pc];
    op   = ins[7:4];
    opd  = ins[3:0];
    m_pc = m_pc + 4'd1;
    // DECODE: run ignored, strobes low
    check("dec_pc", 32'(bus.pc), 32'(m_pc));
    check("dec_outs", 32'(outs()), 32'd0);
    bus.run = 1'($urandom);
    drive_flags();
    tick();
    // EXECUTE
    check("exe_pc", 32'(bus.pc), 32'(m_pc));
    check("exe_outs", 32'(outs()), 32'(exp_exec(op)));
    check("exe_operand", 32'(bus.operand), 32'(opd));
    check("exe_halted", 32'(bus.halted), 32'd0);
    bus.run = 1'($urandom);
    drive_flags();
    take = (op == 4'hA) || (op == 4'hB && bus.zero_flag) || (op == 4'hC && bus.carry_flag);
    if (abort) begin
      reset = 1'b1;
      tick();
      check("abort_outs", 32'(outs()), 32'd0);
      check("abort_pc", 32'(bus.pc), 32'd0);
      reset = 1'b0;
      m_pc  = 4'd0;
      return;
    end
    tick();
    if (take) m_pc = opd;
    if (op == 4'hF) begin
      halted_now = 1'b1;
      check("halt_set", 32'(bus.halted), 32'd1);
    end
  endtask

  task automatic check_parked();
    for (int i = 0; i < 6; i++) begin
      bus.run = 1'(i);
      drive_flags();
      tick();
      check("park_halted", 32'(bus.halted), 32'd1);
      check("park_pc", 32'(bus.pc), 32'(m_pc));
      check("park_outs", 32'(outs()), 32'd0);
    end
  endtask

  initial begin
    bit h;
    reset          = 1'b1;
    bus.run        = 1'b0;
    bus.zero_flag  = 1'b0;
    bus.carry_flag = 1'b0;
    force_run      = 1'b1;
    flag_mode      = 0;
    m_pc           = 4'd0;
    for (int i = 0; i < 16; i++) prog[i] = 8'h00;
    @(negedge clk);

    // Reset, then NOP stream wrapping 14 -> 15 -> 0
    do_reset();
    for (int i = 0; i < 18; i++) do_instr(1'b0, h);

    // ALU sequence: LDI 5, ADD 3, OUT
    prog[0] = 8'h15; prog[1] = 8'h23; prog[2] = 8'h90;
    do_reset();
    for (int i = 0; i < 3; i++) do_instr(1'b0, h);

    // Branches: JZ not taken / taken, JC not taken / taken
    prog[0] = 8'hBA; prog[1] = 8'hBA; prog[10] = 8'hC5; prog[11] = 8'hC5;
    do_reset();
    flag_mode = 1; do_instr(1'b0, h); check("jz_fall", 32'(bus.pc), 32'd1);
    flag_mode = 2; do_instr(1'b0, h); check("jz_take", 32'(bus.pc), 32'hA);
    flag_mode = 1; do_instr(1'b0, h); check("jc_fall", 32'(bus.pc), 32'hB);
    flag_mode = 2; do_instr(1'b0, h); check("jc_take", 32'(bus.pc), 32'h5);
    flag_mode = 0;

    // Undefined opcode then HLT, parked with run toggling
    for (int i = 0; i < 16; i++) prog[i] = 8'h00;
    prog[0] = 8'hD3; prog[1] = 8'hF0;
    do_reset();
    do_instr(1'b0, h);
    check("illegal_one_cycle", 32'(bus.illegal), 32'd0);
    do_instr(1'b0, h);
    check("hlt_seen", 32'(h), 32'd1);
    check_parked();

    // Reset during EXECUTE of STA 4
    prog[0] = 8'h84;
    do_reset();
    do_instr(1'b1, h);
    do_instr(1'b0, h);

    // Random programs with random run gating and flags
    force_run = 1'b0;
    for (int p = 0; p < 12; p++) begin
      for (int i = 0; i < 16; i++) prog[i] = 8'($urandom);
      do_reset();
      for (int n = 0; n < 30; n++) begin
        do_instr(1'b0, h);
        if (h) begin
          check_parked();
          break;
        end
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/cpu_control_unit.md
# cpu_control_unit

Fetch/decode/execute sequencer for the four-bit computer. Owns the program counter, instruction register and control FSM. Drives the strobes that steer the accumulator, ALU, data memory and output register in the datapath. Every instruction takes exactly three cycles, except HLT, which parks the FSM.

## Interface
- `PC_W`, default 4: program counter / program memory address width.
- `INSTR_W`, default 8: instruction width, `{opcode[7:4], operand[3:0]}`.
- `clk` in 1: single clock; all state updates on the rising edge.
- `reset` in 1: synchronous, active-high.
- `run` in 1: 1 = sequence; 0 = hold in FETCH, no state change.
- `instr_data` in 8: program memory read data for address `pc`, combinational read.
- `zero_flag` in 1: accumulator == 0, from the datapath.
- `carry_flag` in 1: ALU carry/borrow, registered in the datapath.
- `pc` out 4: program counter / program memory address.
- `operand` out 4: `IR[3:0]`, immediate or data address.
- `alu_op` out 3: ALU function select.
- `acc_we` out 1: accumulator write strobe.
- `mem_we` out 1: data memory write strobe, address = `operand`.
- `out_we` out 1: output register (`output_data`) write strobe.
- `acc_src` out 1: 0 = ALU result, 1 = data memory read.
- `halted` out 1: FSM in HALT.
- `illegal` out 1: one-cycle pulse on an undefined opcode.

## Operation
- **Opcodes:**
  - 0 NOP
  - 1 LDI (acc=imm)
  - 2 ADD imm
  - 3 SUB imm
  - 4 AND imm
  - 5 OR imm
  - 6 XOR imm
  - 7 LDA addr
  - 8 STA addr
  - 9 OUT
  - A JMP
  - B JZ
  - C JC
  - F HLT
  - D, E undefined
- **alu_op:** 0 PASS_B, 1 ADD, 2 SUB, 3 AND, 4 OR, 5 XOR. Held at PASS_B outside EXECUTE.
- **States:** FETCH → DECODE → EXECUTE → FETCH. HLT enters HALT, which is terminal until reset.
- **FETCH:**
  - When `run`=1: `IR <= instr_data`, `pc <= pc+1`, modulo 16, so 15 wraps to 0.
  - When `run`=0: no change.
- **DECODE:** registers the control word from IR. All strobes remain 0.
- **EXECUTE:** strobes assert for exactly this one cycle.
  - LDI, ADD–XOR: `acc_we`=1, `acc_src`=0, matching `alu_op`.
  - LDA: `acc_we`=1, `acc_src`=1.
  - STA: `mem_we`=1.
  - OUT: `out_we`=1.
  - JMP: `pc <= operand`.
  - JZ / JC: `pc <= operand` if `zero_flag` / `carry_flag` is 1 in this cycle; otherwise `pc` is unchanged.
  - D, E: behave as NOP and assert `illegal`=1.
- **HLT:** EXECUTE goes to HALT.
  - `halted`=1 from the next cycle on.
  - `pc` is frozen and all strobes are 0.
  - `run` is ignored.
- **Flags:** sampled only in EXECUTE and never stored in this block.
- **At most one strobe** among `acc_we`/`mem_we`/`out_we` is high in any cycle.

## Timing
- **Reset values** (after the first edge with `reset`=1):
  - state = FETCH, `pc`=0, IR=0x00 (NOP).
  - All strobes 0, `alu_op`=0, `acc_src`=0, `halted`=0, `illegal`=0.
- **Reset priority:** reset overrides `run`, HALT and any in-flight instruction. No strobe from an aborted EXECUTE appears after the reset edge.
- **Instruction latency:** 3 cycles with `run`=1. Instruction at `pc`=n is fetched at edge k, its strobes are high in cycle k+2, and the next fetch is at edge k+3.
- **Branch timing:** the branch target is visible on `pc` in the cycle after EXECUTE, which is the next FETCH. No delay slot.
- **Wrap-around:** the fall-through `pc` wraps 15 → 0. JMP to 15 is legal.
- **Deasserting `run`:** when `run` drops mid-instruction, the current instruction completes. The FSM then waits in FETCH.
- **Outputs:** all are registered or decoded from registered state only, with no combinational path from `instr_data` to any strobe.

## Structure
- **Package `cpu_pkg`:** opcode constants, `alu_op` encodings, the FSM state enum, and `PC_W`/`INSTR_W`. The package is shared with the datapath and the assembler test vectors.
- **Sub-module `cpu_decoder`:** purely combinational, opcode + flags → control word (`alu_op`, `acc_we`, `mem_we`, `out_we`, `acc_src`, `pc_load`, `illegal`).
- **Top level:** `cpu_control_unit` holds the PC, IR and FSM, and registers the decoder output in DECODE.

## Test plan
- **Reset:**
  - Stimulus: `reset`=1 for 2 cycles, then release with `run`=1 and `instr_data`=0x00.
  - Response: `pc` goes 0→1 after 1 edge and reaches 2 after 4 edges. No strobe ever asserts.
- **ALU sequence:**
  - Stimulus: program LDI 5, ADD 3, OUT.
  - Response: `acc_we` pulses in cycles 2 and 5 with `alu_op` 0 then 1. `out_we` pulses in cycle 8, `operand`=3 at the ADD strobe.
- **Branches:**
  - Stimulus: JZ 0xA with `zero_flag`=0, then JZ 0xA with `zero_flag`=1.
  - Response: first case `pc` = fetch address + 1. Second case `pc`=0xA at the next FETCH. JC checked the same way with `carry_flag`.
- **Wrap:**
  - Stimulus: NOP at addresses 14, 15, 0.
  - Response: `pc` sequence 14→15→0 with no glitch.
- **HLT and undefined opcode:**
  - Stimulus: opcode 0xD, then opcode 0xF.
  - Response: `illegal`=1 for exactly one cycle. `halted`=1 three cycles after the HLT fetch and stays high with `run` toggling.
- **Reset mid-EXECUTE:**
  - Stimulus: assert `reset` during the EXECUTE of STA 4.
  - Response: `mem_we` is 0 after the reset edge, and `pc`=0 in the next cycle.
